// File: rtl/bcd_countdown_timer_if.sv
// Control and display signals between the timer, its controller and the display driver.
interface bcd_countdown_timer_if;
  logic       tick;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output tick, load, preset_min, preset_sec, start, pause,
    input  min_bcd, sec_bcd, running, done, expired
  );

  modport slave (
    input  tick, load, preset_min, preset_sec, start, pause,
    output min_bcd, sec_bcd, running, done, expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: load/start/pause control, one-second decrement every
// TICKS_PER_SEC counted ticks, one-cycle done pulse and sticky expired flag.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_countdown_timer_if.slave  bus
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    min_q, min_n, sec_q, sec_n;
  logic          running_q, done_q, done_n, expired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      running_q <= (state_n == RUN);
      done_q    <= done_n;
      expired_q <= (state_n == EXPIRED);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    min_n   = min_q;
    sec_n   = sec_q;
    done_n  = 1'b0;
    if (bus.load) begin
      min_n[7:4] = (bus.preset_min[7:4] > 4'd9) ? 4'd9 : bus.preset_min[7:4];
      min_n[3:0] = (bus.preset_min[3:0] > 4'd9) ? 4'd9 : bus.preset_min[3:0];
      sec_n[7:4] = (bus.preset_sec[7:4] > 4'd5) ? 4'd5 : bus.preset_sec[7:4];
      sec_n[3:0] = (bus.preset_sec[3:0] > 4'd9) ? 4'd9 : bus.preset_sec[3:0];
      cnt_n      = '0;
      state_n    = IDLE;
    end else if (bus.pause) begin
      if (state == RUN) state_n = PAUSED;
    end else if (bus.start) begin
      if ((state == IDLE && {min_q, sec_q} != 16'h0000) || state == PAUSED)
        state_n = RUN;
    end else if (bus.tick && state == RUN) begin
      if (cnt == CNT_LAST) begin
        cnt_n = '0;
        // Borrow chain; RUN is never entered at 00:00 so no wrap guard is needed.
        if (sec_q[3:0] != 4'd0) sec_n[3:0] = sec_q[3:0] - 4'd1;
        else begin
          sec_n[3:0] = 4'd9;
          if (sec_q[7:4] != 4'd0) sec_n[7:4] = sec_q[7:4] - 4'd1;
          else begin
            sec_n[7:4] = 4'd5;
            if (min_q[3:0] != 4'd0) min_n[3:0] = min_q[3:0] - 4'd1;
            else begin
              min_n[3:0] = 4'd9;
              min_n[7:4] = min_q[7:4] - 4'd1;
            end
          end
        end
        if ({min_n, sec_n} == 16'h0000) begin
          state_n = EXPIRED;
          done_n  = 1'b1;
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: one timer at 2 ticks/s and one at 5 ticks/s share the same stimulus.
module tb_bcd_countdown_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if ia ();
  bcd_countdown_timer_if ib ();

  bcd_countdown_timer #(.TICKS_PER_SEC(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  bcd_countdown_timer #(.TICKS_PER_SEC(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic tk, input logic ld, input logic st, input logic ps);
    ia.tick = tk; ia.load = ld; ia.start = st; ia.pause = ps;
    ib.tick = tk; ib.load = ld; ib.start = st; ib.pause = ps;
  endtask

  // Apply one cycle of control, then sample #1 after the edge.
  task automatic step(input logic tk, input logic ld, input logic st, input logic ps);
    @(negedge clk);
    drive(tk, ld, st, ps);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_val(input logic [7:0] m, input logic [7:0] s);
    ia.preset_min = m; ia.preset_sec = s;
    ib.preset_min = m; ib.preset_sec = s;
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] dig_a(); return {ia.min_bcd, ia.sec_bcd}; endfunction
  function automatic logic [15:0] dig_b(); return {ib.min_bcd, ib.sec_bcd}; endfunction
  function automatic logic [15:0] flg_a(); return {13'd0, ia.running, ia.done, ia.expired}; endfunction
  function automatic logic [15:0] flg_b(); return {13'd0, ib.running, ib.done, ib.expired}; endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ia.preset_min = 8'h00; ia.preset_sec = 8'h00;
    ib.preset_min = 8'h00; ib.preset_sec = 8'h00;

    // Reset, then idle with ticks and a start at 00:00
    #12;
    chk("rst_dig_a", dig_a(), 16'h0000);
    chk("rst_flg_a", flg_a(), 16'h0000);
    chk("rst_flg_b", flg_b(), 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    ticks(3);
    chk("idle_tick_dig", dig_a(), 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_start0_flg", flg_a(), 16'h0000);

    // Basic count at 2 ticks/s
    load_val(8'h00, 8'h03);
    chk("basic_load", dig_a(), 16'h0003);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_run", flg_a(), 16'h0004);
    ticks(1);
    chk("basic_t1", dig_a(), 16'h0003);
    ticks(1);
    chk("basic_t2", dig_a(), 16'h0002);
    ticks(2);
    chk("basic_t4", dig_a(), 16'h0001);
    ticks(2);
    chk("basic_t6_dig", dig_a(), 16'h0000);
    chk("basic_t6_flg", flg_a(), 16'h0003);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("basic_done_1cyc", flg_a(), 16'h0001);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_exp_start", flg_a(), 16'h0001);

    // Borrow chains
    load_val(8'h10, 8'h00);
    chk("load_clr_exp", flg_a(), 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("borrow_1000", dig_a(), 16'h0959);
    load_val(8'h01, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("borrow_0100", dig_a(), 16'h0059);

    // Pause/resume at 5 ticks/s: sub-count of 3 survives the pause
    load_val(8'h00, 8'h02);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("pause_flg", flg_b(), 16'h0000);
    ticks(10);
    chk("pause_hold", dig_b(), 16'h0002);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("resume_flg", flg_b(), 16'h0004);
    ticks(1);
    chk("resume_t4", dig_b(), 16'h0002);
    ticks(1);
    chk("resume_t5", dig_b(), 16'h0001);

    // Clamp, then load beats a tick that would decrement
    load_val(8'hAB, 8'h7F);
    chk("clamp", dig_a(), 16'h9959);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    ia.preset_min = 8'h00; ia.preset_sec = 8'h05;
    ib.preset_min = 8'h00; ib.preset_sec = 8'h05;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ld_tick_dig", dig_a(), 16'h0005);
    chk("ld_tick_flg", flg_a(), 16'h0000);
    ticks(2);
    chk("ld_tick_idle", dig_a(), 16'h0005);

    // Asynchronous reset mid-run
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("arst_dig", dig_a(), 16'h0000);
    chk("arst_flg", flg_a(), 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    ticks(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("post_rst_dig", dig_a(), 16'h0000);
    chk("post_rst_flg", flg_a(), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
